row_idct: RTL and testbench



---
 rtl/idct_pkg.sv | 25 ++
 rtl/idct_round_sat.sv | 30 +++
 rtl/row_idct.sv | 175 +++++++++++++++++
 tb/tb_row_idct.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/idct_pkg.sv
// Shared constants and types for the 8-point row inverse DCT.
package idct_pkg;

  localparam int IN_W  = 14;
  localparam int OUT_W = 11;
  localparam int FRAC  = 12;
  localparam int ACC_W = 28;

  typedef logic signed [IN_W-1:0]  coef_t;
  typedef logic signed [ACC_W-1:0] acc_t;
  typedef logic signed [OUT_W-1:0] samp_t;

  // Cosine constants: round(2^FRAC * 0.5 * cos(m*pi/16)); W4 doubles as the DC weight.
  localparam acc_t W1 = acc_t'(2009);
  localparam acc_t W2 = acc_t'(1892);
  localparam acc_t W3 = acc_t'(1703);
  localparam acc_t W4 = acc_t'(1448);
  localparam acc_t W5 = acc_t'(1138);
  localparam acc_t W6 = acc_t'(784);
  localparam acc_t W7 = acc_t'(400);

  // Odd-part weights, indexed 0..3 for W1, W3, W5, W7.
  localparam acc_t W_ODD [4] = '{W1, W3, W5, W7};

endpackage

// File: rtl/idct_round_sat.sv
// Converts one accumulator value to an output sample: add half an LSB,
// arithmetic shift out the fraction, then clamp to the sample range.
module idct_round_sat
  import idct_pkg::*;
(
  input  logic signed [ACC_W-1:0] i_acc,
  output logic signed [OUT_W-1:0] o_samp
);

  localparam acc_t HALF   = acc_t'(2 ** (FRAC - 1));
  localparam acc_t SAT_HI = acc_t'(2 ** (OUT_W - 1) - 1);
  localparam acc_t SAT_LO = acc_t'(-(2 ** (OUT_W - 1)));

  acc_t rounded;
  acc_t shifted;

  // Round half toward +inf, then saturate.
  always_comb begin
    rounded = i_acc + HALF;
    shifted = rounded >>> FRAC;
    if (shifted > SAT_HI) begin
      o_samp = samp_t'(SAT_HI);
    end else if (shifted < SAT_LO) begin
      o_samp = samp_t'(SAT_LO);
    end else begin
      o_samp = shifted[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/row_idct.sv
// 8-point 1-D inverse DCT for one row. Four-stage pipeline:
// S1 capture/sign-extend, S2 products, S3 even/odd sums, S4 butterfly + round/saturate.
// A single advance enable stalls every stage together when the output is held.
module row_idct
  import idct_pkg::*;
(
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic signed [IN_W-1:0]  i_data0,
  input  logic signed [IN_W-1:0]  i_data1,
  input  logic signed [IN_W-1:0]  i_data2,
  input  logic signed [IN_W-1:0]  i_data3,
  input  logic signed [IN_W-1:0]  i_data4,
  input  logic signed [IN_W-1:0]  i_data5,
  input  logic signed [IN_W-1:0]  i_data6,
  input  logic signed [IN_W-1:0]  i_data7,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic signed [OUT_W-1:0] o_data0,
  output logic signed [OUT_W-1:0] o_data1,
  output logic signed [OUT_W-1:0] o_data2,
  output logic signed [OUT_W-1:0] o_data3,
  output logic signed [OUT_W-1:0] o_data4,
  output logic signed [OUT_W-1:0] o_data5,
  output logic signed [OUT_W-1:0] o_data6,
  output logic signed [OUT_W-1:0] o_data7
);

  logic  adv;
  coef_t in_data [8];

  logic  s1_valid_reg;
  logic  s2_valid_reg;
  logic  s3_valid_reg;
  logic  o_valid_reg;

  acc_t  x_reg [8];

  acc_t  w4x0_reg;
  acc_t  w2x2_reg;
  acc_t  w6x2_reg;
  acc_t  w4x4_reg;
  acc_t  w2x6_reg;
  acc_t  w6x6_reg;
  acc_t  odd_reg [4][4];   // [j][m] = W_ODD[m] * X(2j+1)

  acc_t  a_next [4];
  acc_t  b_next [4];
  acc_t  a_reg  [4];
  acc_t  b_reg  [4];

  acc_t  x_sum  [8];
  samp_t samp_next  [8];
  samp_t o_data_reg [8];

  // The whole pipe moves whenever the output slot is empty or being drained.
  assign adv     = ~o_valid_reg | i_ready;
  assign o_ready = adv;
  assign o_valid = o_valid_reg;

  assign in_data[0] = i_data0;
  assign in_data[1] = i_data1;
  assign in_data[2] = i_data2;
  assign in_data[3] = i_data3;
  assign in_data[4] = i_data4;
  assign in_data[5] = i_data5;
  assign in_data[6] = i_data6;
  assign in_data[7] = i_data7;

  // Stage valid chain; reset flushes every in-flight row.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
      s3_valid_reg <= 1'b0;
      o_valid_reg  <= 1'b0;
    end else if (adv) begin
      s1_valid_reg <= i_valid;
      s2_valid_reg <= s1_valid_reg;
      s3_valid_reg <= s2_valid_reg;
      o_valid_reg  <= s3_valid_reg;
    end
  end

  // S1: capture coefficients sign-extended to accumulator width.
  always_ff @(posedge i_clk) begin
    if (adv) begin
      for (int k = 0; k < 8; k++) begin
        x_reg[k] <= acc_t'(in_data[k]);
      end
    end
  end

  // S2: every weight-by-coefficient product the sums below need.
  always_ff @(posedge i_clk) begin
    if (adv) begin
      w4x0_reg <= W4 * x_reg[0];
      w2x2_reg <= W2 * x_reg[2];
      w6x2_reg <= W6 * x_reg[2];
      w4x4_reg <= W4 * x_reg[4];
      w2x6_reg <= W2 * x_reg[6];
      w6x6_reg <= W6 * x_reg[6];
      for (int j = 0; j < 4; j++) begin
        for (int m = 0; m < 4; m++) begin
          odd_reg[j][m] <= W_ODD[m] * x_reg[2*j+1];
        end
      end
    end
  end

  // S3 combinational: even part from X0/X2/X4/X6, odd part from X1/X3/X5/X7.
  always_comb begin
    a_next[0] = w4x0_reg + w2x2_reg + w4x4_reg + w6x6_reg;
    a_next[1] = w4x0_reg + w6x2_reg - w4x4_reg - w2x6_reg;
    a_next[2] = w4x0_reg - w6x2_reg - w4x4_reg + w2x6_reg;
    a_next[3] = w4x0_reg - w2x2_reg + w4x4_reg - w6x6_reg;

    b_next[0] = odd_reg[0][0] + odd_reg[1][1] + odd_reg[2][2] + odd_reg[3][3];
    b_next[1] = odd_reg[0][1] - odd_reg[1][3] - odd_reg[2][0] - odd_reg[3][2];
    b_next[2] = odd_reg[0][2] - odd_reg[1][0] + odd_reg[2][3] + odd_reg[3][1];
    b_next[3] = odd_reg[0][3] - odd_reg[1][2] + odd_reg[2][1] - odd_reg[3][0];
  end

  // S3: register even and odd partial sums.
  always_ff @(posedge i_clk) begin
    if (adv) begin
      for (int i = 0; i < 4; i++) begin
        a_reg[i] <= a_next[i];
        b_reg[i] <= b_next[i];
      end
    end
  end

  // S4: butterfly pairs sample n with sample 7-n.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_bfly
      assign x_sum[gi]     = a_reg[gi] + b_reg[gi];
      assign x_sum[7 - gi] = a_reg[gi] - b_reg[gi];
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_rsat
      idct_round_sat u_rsat (
        .i_acc  (x_sum[gi]),
        .o_samp (samp_next[gi])
      );
    end
  endgenerate

  // S4: output registers, cleared by reset and held while stalled.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int n = 0; n < 8; n++) begin
        o_data_reg[n] <= '0;
      end
    end else if (adv) begin
      for (int n = 0; n < 8; n++) begin
        o_data_reg[n] <= samp_next[n];
      end
    end
  end

  assign o_data0 = o_data_reg[0];
  assign o_data1 = o_data_reg[1];
  assign o_data2 = o_data_reg[2];
  assign o_data3 = o_data_reg[3];
  assign o_data4 = o_data_reg[4];
  assign o_data5 = o_data_reg[5];
  assign o_data6 = o_data_reg[6];
  assign o_data7 = o_data_reg[7];

endmodule

// File: tb/tb_row_idct.sv
// Self-checking bench for row_idct: hand-computed vector table, random rows
// against a direct cosine-matrix model, backpressure and mid-stream reset.
module tb_row_idct;
  import idct_pkg::*;

  typedef logic [7:0][IN_W-1:0]  irow_t;
  typedef logic [7:0][OUT_W-1:0] orow_t;
  typedef struct packed {
    irow_t x;
    orow_t y;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_valid = 1'b0;
  logic i_ready = 1'b1;
  logic o_ready;
  logic o_valid;
  logic signed [IN_W-1:0]  d [8];
  logic signed [OUT_W-1:0] q [8];

  int    n_cmp = 0;
  int    n_err = 0;
  int    n_out = 0;
  orow_t cur_exp;
  orow_t exp_q [$];
  logic  prev_stall = 1'b0;
  orow_t prev_q;
  vec_t  tv [7];

  always #5 clk = ~clk;

  row_idct dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data0 (d[0]), .i_data1 (d[1]), .i_data2 (d[2]), .i_data3 (d[3]),
    .i_data4 (d[4]), .i_data5 (d[5]), .i_data6 (d[6]), .i_data7 (d[7]),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data0 (q[0]), .o_data1 (q[1]), .o_data2 (q[2]), .o_data3 (q[3]),
    .o_data4 (q[4]), .o_data5 (q[5]), .o_data6 (q[6]), .o_data7 (q[7])
  );

  // Reference: x[n] = sum_k c(n,k) X[k], c from the folded cosine index (2n+1)k mod 32.
  function automatic orow_t model(input irow_t x);
    int    wt [9] = '{1448, 2009, 1892, 1703, 1448, 1138, 784, 400, 0};
    orow_t y;
    for (int n = 0; n < 8; n++) begin
      longint s = 0;
      longint r;
      for (int k = 0; k < 8; k++) begin
        int m  = ((2*n + 1) * k) % 32;
        int sg = 1;
        if (m > 16) m = 32 - m;
        if (m > 8) begin
          m  = 16 - m;
          sg = -1;
        end
        s += longint'(sg * wt[m] * int'($signed(x[k])));
      end
      r = (s + 2048) >>> 12;
      if (r > 1023) r = 1023;
      if (r < -1024) r = -1024;
      y[n] = r[OUT_W-1:0];
    end
    return y;
  endfunction

  function automatic vec_t mkv(input int xs [8], input int ys [8]);
    vec_t v;
    for (int k = 0; k < 8; k++) begin
      v.x[k] = xs[k][IN_W-1:0];
      v.y[k] = ys[k][OUT_W-1:0];
    end
    return v;
  endfunction

  function automatic irow_t rand_row(input bit wide);
    irow_t x;
    for (int k = 0; k < 8; k++) begin
      int v = int'($urandom_range(0, 1023)) - 512;
      if (wide) v = int'($urandom_range(0, 16383)) - 8192;
      x[k] = v[IN_W-1:0];
    end
    return x;
  endfunction

  function automatic orow_t pack_q();
    orow_t r;
    for (int n = 0; n < 8; n++) r[n] = q[n];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  task automatic apply(input irow_t x, input orow_t y);
    for (int k = 0; k < 8; k++) d[k] = x[k];
    cur_exp = y;
    i_valid = 1'b1;
  endtask

  // Scoreboard push on every input transfer; reset discards in-flight rows.
  always @(posedge clk) begin
    if (!rst_n) exp_q.delete();
    else if (i_valid && o_ready) exp_q.push_back(cur_exp);
  end

  // Output checks at the falling edge: transfers, stall stability, o_ready under stall.
  always @(negedge clk) begin
    orow_t got;
    got = pack_q();
    if (rst_n && prev_stall) begin
      n_cmp++;
      if (got !== prev_q || o_valid !== 1'b1) begin
        n_err++;
        $display("FAIL stall_hold: got %h valid %b, expected %h valid 1", got, o_valid, prev_q);
      end
    end
    if (rst_n && o_valid && !i_ready) begin
      n_cmp++;
      if (o_ready !== 1'b0) begin
        n_err++;
        $display("FAIL stall_ready: got o_ready %b, expected 0", o_ready);
      end
    end
    if (rst_n && o_valid && i_ready) begin
      n_cmp++;
      n_out++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_row: got %h, expected no output", got);
      end else begin
        orow_t e;
        e = exp_q.pop_front();
        if (got !== e) begin
          n_err++;
          $display("FAIL row_out %0d: got %h, expected %h", n_out, got, e);
        end else begin
          $display("row %0d out %0d %0d %0d %0d %0d %0d %0d %0d", n_out,
                   q[0], q[1], q[2], q[3], q[4], q[5], q[6], q[7]);
        end
      end
    end
    prev_stall = rst_n && o_valid && !i_ready;
    prev_q     = got;
  end

  initial begin
    int    cnt;
    int    idx;
    bit    need_new;
    irow_t bx;

    tv[0] = mkv('{100, 0, 0, 0, 0, 0, 0, 0}, '{35, 35, 35, 35, 35, 35, 35, 35});
    tv[1] = mkv('{0, 64, 0, 0, 0, 0, 0, 0},  '{31, 27, 18, 6, -6, -18, -27, -31});
    tv[2] = mkv('{0, 0, 100, 0, 0, 0, 0, 0}, '{46, 19, -19, -46, -46, -19, 19, 46});
    tv[3] = mkv('{8191, 0, 0, 0, 0, 0, 0, 0}, '{1023, 1023, 1023, 1023, 1023, 1023, 1023, 1023});
    tv[4] = mkv('{-8192, 0, 0, 0, 0, 0, 0, 0}, '{-1024, -1024, -1024, -1024, -1024, -1024, -1024, -1024});
    tv[5] = mkv('{256, 0, 0, 0, 0, 0, 0, 0},  '{91, 91, 91, 91, 91, 91, 91, 91});
    tv[6] = mkv('{-256, 0, 0, 0, 0, 0, 0, 0}, '{-90, -90, -90, -90, -90, -90, -90, -90});
    for (int k = 0; k < 8; k++) d[k] = '0;
    cur_exp = '0;

    // Reset state
    tick();
    tick();
    chk("rst_o_valid", o_valid, 0);
    chk("rst_o_ready", o_ready, 1);
    for (int n = 0; n < 8; n++) chk("rst_o_data", q[n], 0);
    rst_n = 1'b1;

    // Latency: first row accepted on the first cycle out of reset, o_valid four edges later
    apply(tv[0].x, tv[0].y);
    tick();
    i_valid = 1'b0;
    tick();
    tick();
    chk("latency_early", o_valid, 0);
    tick();
    chk("latency_4", o_valid, 1);

    // Table vectors on consecutive cycles
    for (int i = 1; i < 7; i++) begin
      apply(tv[i].x, tv[i].y);
      tick();
    end
    i_valid = 1'b0;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) tick();
    chk("table_drain", exp_q.size(), 0);

    // Ten random rows back to back; expect ten consecutive output cycles
    cnt = 0;
    for (int r = 0; r < 10; r++) begin
      bx = rand_row(r % 4 == 3);
      apply(bx, model(bx));
      tick();
      if (o_valid) cnt++;
    end
    i_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (o_valid) cnt++;
    end
    chk("b2b_out_cycles", cnt, 10);

    // Backpressure: i_ready low for five cycles while streaming
    idx = 0;
    need_new = 1'b1;
    for (int cyc = 0; cyc < 60 && idx < 12; cyc++) begin
      i_ready = !(cyc >= 6 && cyc < 11);
      if (need_new) begin
        bx = rand_row(1'b0);
        apply(bx, model(bx));
        need_new = 1'b0;
      end
      #1;
      if (o_ready) begin
        idx++;
        need_new = 1'b1;
      end
      tick();
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    chk("bp_rows_sent", idx, 12);
    for (int c = 0; c < 50 && (exp_q.size() != 0 || o_valid); c++) tick();
    chk("bp_drain", exp_q.size(), 0);

    // Reset with three rows in flight, then a fresh row
    for (int r = 0; r < 3; r++) begin
      bx = rand_row(1'b0);
      apply(bx, model(bx));
      tick();
    end
    i_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("flush_o_valid", o_valid, 0);
    apply(tv[1].x, tv[1].y);
    tick();
    i_valid = 1'b0;
    tick();
    tick();
    chk("post_rst_early", o_valid, 0);
    tick();
    chk("post_rst_valid", o_valid, 1);

    // Final drain, bounded
    for (int c = 0; c < 50 && (exp_q.size() != 0 || o_valid); c++) tick();
    chk("final_drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
